floppy_timer_sched: RTL and testbench



---
 rtl/floppy_timer_sched.sv | 93 +++++++++
 tb/tb_floppy_timer_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floppy_timer_sched.sv
// Shared tick scheduler: one prescaler produces a TICKHZ tick that drives four 8-bit
// countdown channels with sticky expiry flags, an interrupt mask and a level irq.
module floppy_timer_sched #(
    parameter int unsigned MCLKFREQ = 24000000,
    parameter int unsigned TICKHZ   = 100,
    parameter int unsigned PSW      = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] addr,
    input  logic [7:0] di,
    input  logic       wren,
    input  logic       rden,
    output logic [7:0] dout,
    output logic       irq,
    output logic       tick
);

    localparam int unsigned RELOAD = MCLKFREQ / TICKHZ - 1;
    localparam logic [PSW-1:0] RELOAD_V = PSW'(RELOAD);

    logic [PSW-1:0]  psc_q, psc_d;
    logic            run_q, run_d;
    logic [3:0][7:0] ch_q, ch_d;
    logic [3:0]      flags_q, flags_d;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      flag_set;
    logic [3:0]      flag_clr;
    logic            resync;
    logic            irq_d;
    logic [7:0]      rdata;

    always_comb begin
        resync = wren && (addr == 3'd6) && di[1];
        // A resync in the same cycle swallows the tick the old phase would have produced.
        tick   = run_q && (psc_q == '0) && !resync;

        psc_d = psc_q;
        if (resync) begin
            psc_d = RELOAD_V;
        end else if (run_q) begin
            psc_d = (psc_q == '0) ? RELOAD_V : psc_q - PSW'(1);
        end

        flag_set = '0;
        for (int n = 0; n < 4; n++) begin
            ch_d[n] = ch_q[n];
            if (wren && (addr == 3'(n))) begin
                ch_d[n] = di;
            end else if (tick && (ch_q[n] != 8'd0)) begin
                ch_d[n] = ch_q[n] - 8'd1;
                flag_set[n] = (ch_q[n] == 8'd1);
            end
        end

        flag_clr = (wren && (addr == 3'd4)) ? di[3:0] : 4'd0;
        flags_d  = (flags_q & ~flag_clr) | flag_set;
        mask_d   = (wren && (addr == 3'd5)) ? di[3:0] : mask_q;
        run_d    = (wren && (addr == 3'd6)) ? di[0] : run_q;
        irq_d    = |(flags_q & mask_q);

        case (addr)
            3'd0, 3'd1, 3'd2, 3'd3: rdata = ch_q[addr[1:0]];
            3'd4:                   rdata = {4'd0, flags_q};
            3'd5:                   rdata = {4'd0, mask_q};
            3'd6:                   rdata = {7'd0, run_q};
            default:                rdata = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q   <= RELOAD_V;
            run_q   <= 1'b1;
            ch_q    <= '0;
            flags_q <= '0;
            mask_q  <= '0;
            irq     <= 1'b0;
            dout    <= 8'd0;
        end else begin
            psc_q   <= psc_d;
            run_q   <= run_d;
            ch_q    <= ch_d;
            flags_q <= flags_d;
            mask_q  <= mask_d;
            irq     <= irq_d;
            if (rden) begin
                dout <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_floppy_timer_sched.sv
// Bench for floppy_timer_sched: directed scenarios plus random bus traffic, all checked
// against a cycle-level behavioural model of the register file and tick scheduler.
module tb_floppy_timer_sched;

    localparam int unsigned MCLK   = 1000;
    localparam int unsigned THZ    = 100;
    localparam int unsigned PSW    = 18;
    localparam int unsigned RELOAD = MCLK / THZ - 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] addr  = 3'd0;
    logic [7:0] di    = 8'd0;
    logic       wren  = 1'b0;
    logic       rden  = 1'b0;
    logic [7:0] dout;
    logic       irq;
    logic       tick;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    floppy_timer_sched #(
        .MCLKFREQ(MCLK),
        .TICKHZ  (THZ),
        .PSW     (PSW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .di   (di),
        .wren (wren),
        .rden (rden),
        .dout (dout),
        .irq  (irq),
        .tick (tick)
    );

    // Model: phase counts cycles since the last tick (up-counter); tick when it hits RELOAD.
    int       m_phase;
    bit       m_run;
    int       m_ch[4];
    bit [3:0] m_flags;
    bit [3:0] m_mask;
    bit       m_irq;
    bit [7:0] m_do;

    function automatic bit exp_tick();
        return m_run && (m_phase == RELOAD) && !(wren && addr == 3'd6 && di[1]);
    endfunction

    function automatic bit [7:0] m_read(input int a);
        if (a < 4) return 8'(m_ch[a]);
        if (a == 4) return {4'd0, m_flags};
        if (a == 5) return {4'd0, m_mask};
        if (a == 6) return {7'd0, m_run};
        return 8'd0;
    endfunction

    task automatic model_step();
        bit       t   = exp_tick();
        bit [3:0] set = 4'd0;
        bit [3:0] clr;
        if (rden) m_do = m_read(int'(addr));
        m_irq = |(m_flags & m_mask);
        for (int n = 0; n < 4; n++) begin
            if (wren && addr == 3'(n)) begin
                m_ch[n] = int'(di);
            end else if (t && m_ch[n] > 0) begin
                m_ch[n] = m_ch[n] - 1;
                if (m_ch[n] == 0) set[n] = 1'b1;
            end
        end
        clr = (wren && addr == 3'd4) ? di[3:0] : 4'd0;
        m_flags = (m_flags & ~clr) | set;
        if (wren && addr == 3'd5) m_mask = di[3:0];
        if (wren && addr == 3'd6 && di[1]) m_phase = 0;
        else if (m_run) m_phase = (m_phase == RELOAD) ? 0 : m_phase + 1;
        if (wren && addr == 3'd6) m_run = di[0];
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_run   = 1'b1;
            for (int n = 0; n < 4; n++) m_ch[n] = 0;
            m_flags = 4'd0;
            m_mask  = 4'd0;
            m_irq   = 1'b0;
            m_do    = 8'd0;
        end else begin
            model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("tick", 32'(tick), 32'(exp_tick()));
        check("irq", 32'(irq), 32'(m_irq));
        check("do", 32'(dout), 32'(m_do));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        addr = 3'(a);
        di   = 8'(d);
        wren = 1'b1;
        cyc();
        wren = 1'b0;
    endtask

    task automatic rd(input int a);
        addr = 3'(a);
        rden = 1'b1;
        cyc();
        rden = 1'b0;
    endtask

    // Leaves the bench inside a tick cycle, so the next access shares the tick edge.
    task automatic sync_to_tick();
        for (int i = 0; i < 40; i++) begin
            if (m_run && m_phase == RELOAD) return;
            cyc();
        end
        tests++;
        fails++;
        $display("FAIL sync_to_tick: got no tick expected tick within 40 cycles");
    endtask

    initial begin
        int n;
        int cnt;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First tick lands on edge 10 after release, then every 10 edges.
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (tick) break;
        end
        check("first_tick_edge", 32'(n + 1), 32'd10);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (tick) break;
        end
        check("tick_period", 32'(n), 32'd10);

        cyc();
        for (int a = 0; a < 8; a++) begin
            rd(a);
            check("reg_reset", 32'(dout), (a == 6) ? 32'd1 : 32'd0);
        end

        // Countdown with irq follow-through.
        wr(2, 3);
        wr(5, 4);
        repeat (3) begin
            sync_to_tick();
            cyc();
        end
        rd(2);
        check("ch2_expired", 32'(dout), 32'd0);
        rd(4);
        check("flags_ch2", 32'(dout), 32'h04);
        check("irq_on", 32'(irq), 32'd1);
        sync_to_tick();
        cyc();
        rd(2);
        check("ch2_idle", 32'(dout), 32'd0);
        wr(4, 4);
        check("irq_lag", 32'(irq), 32'd1);
        cyc();
        check("irq_off", 32'(irq), 32'd0);

        // Load collides with tick while CH0 = 1.
        sync_to_tick();
        cyc();
        wr(0, 1);
        sync_to_tick();
        wr(0, 5);
        rd(0);
        check("collide_ch0", 32'(dout), 32'd5);
        rd(4);
        check("collide_flags", 32'(dout), 32'd0);

        // Set beats clear on the same cycle.
        sync_to_tick();
        cyc();
        wr(0, 1);
        sync_to_tick();
        wr(4, 1);
        rd(4);
        check("set_wins", 32'(dout), 32'h01);
        wr(4, 1);

        // Two channels expiring on one tick, one masked.
        sync_to_tick();
        cyc();
        wr(1, 2);
        wr(3, 2);
        wr(5, 2);
        repeat (2) begin
            sync_to_tick();
            cyc();
        end
        cyc();
        rd(4);
        check("multi_flags", 32'(dout), 32'h0A);
        check("multi_irq", 32'(irq), 32'd1);
        wr(5, 0);
        cyc();
        check("masked_irq", 32'(irq), 32'd0);
        rd(4);
        check("masked_flags", 32'(dout), 32'h0A);
        wr(4, 15);

        // RUN = 0 freezes everything; RESYNC restarts a full period.
        wr(6, 0);
        wr(2, 9);
        cnt = 0;
        repeat (50) begin
            cyc();
            if (tick) cnt++;
        end
        check("stopped_ticks", 32'(cnt), 32'd0);
        rd(2);
        check("frozen_ch2", 32'(dout), 32'd9);
        wr(6, 3);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tick) break;
            @(posedge clk);
            n++;
        end
        check("resync_delay", 32'(n + 1), 32'd10);
        cyc();
        rd(6);
        check("ctrl_read", 32'(dout), 32'h01);

        // Random bus traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            int r = int'($urandom_range(0, 9));
            int a = int'($urandom_range(0, 7));
            wren = (r < 3);
            rden = (r >= 2 && r < 6);
            addr = 3'(a);
            if (a < 4) di = 8'($urandom_range(0, 4));
            else if (a == 6) di = {6'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
            else di = 8'($urandom);
            cyc();
        end
        wren = 1'b0;
        rden = 1'b0;

        // Asynchronous reset mid-countdown.
        wr(6, 1);
        wr(4, 15);
        wr(5, 1);
        wr(0, 1);
        sync_to_tick();
        cyc();
        cyc();
        wr(0, 7);
        rd(0);
        check("pre_reset_do", 32'(dout), 32'd7);
        check("pre_reset_irq", 32'(irq), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_do", 32'(dout), 32'd0);
        check("async_irq", 32'(irq), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        rd(0);
        check("post_reset_ch0", 32'(dout), 32'd0);
        rd(4);
        check("post_reset_flags", 32'(dout), 32'd0);
        rd(6);
        check("post_reset_ctrl", 32'(dout), 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
